// File: rtl/mem_port_if.sv
// mem_port_if: request/response bundle between the control unit and mem_port
interface mem_port_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              rdm_load;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  busy, done, rdm_load, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, done, rdm_load, rdata
    );
endinterface

// File: rtl/mem_port.sv
// mem_port: fixed-latency sequencer around a word-addressed RAM feeding the data register
module mem_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input logic       clk,
    input logic       rst,
    mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    state_t            state;
    state_t            state_n;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              commit;

    assign commit = (state == ACCESS) && (cnt == 4'd0);

    // state register; reset forces IDLE from anywhere
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state: accept in IDLE, leave ACCESS when the counter expires, RESP lasts one cycle
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = bus.req ? ACCESS : IDLE;
            ACCESS:  state_n = (cnt == 4'd0) ? RESP : ACCESS;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // request capture, latency countdown and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                cnt     <= CNT_INIT;
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !we_q)
                rdata_q <= mem[addr_q];
        end
    end

    // RAM write port; reset on the commit edge aborts the write, contents are never cleared
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q)
            mem[addr_q] <= wdata_q;
    end

    // outputs decoded purely from registered state
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.done     = (state == RESP);
        bus.rdm_load = (state == RESP) && !we_q;
        bus.rdata    = rdata_q;
    end
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: randomized and directed checks of mem_port at RD_LAT 2, 1 and 15
module tb_mem_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          sel;

    logic        busy;
    logic        done;
    logic        rdm_load;
    logic [15:0] rdata;

    int          lat [3] = '{2, 1, 15};
    logic [15:0] mem_m [3][256];
    bit          val_m [3][256];
    logic [15:0] rd_m [3];
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    mem_port_if b0 ();
    mem_port_if b1 ();
    mem_port_if b2 ();

    assign b0.req = req && (sel == 0);
    assign b1.req = req && (sel == 1);
    assign b2.req = req && (sel == 2);
    assign b0.we = we;
    assign b1.we = we;
    assign b2.we = we;
    assign b0.addr = addr;
    assign b1.addr = addr;
    assign b2.addr = addr;
    assign b0.wdata = wdata;
    assign b1.wdata = wdata;
    assign b2.wdata = wdata;

    mem_port #(.RD_LAT(2))  d0 (.clk(clk), .rst(rst), .bus(b0));
    mem_port #(.RD_LAT(1))  d1 (.clk(clk), .rst(rst), .bus(b1));
    mem_port #(.RD_LAT(15)) d2 (.clk(clk), .rst(rst), .bus(b2));

    always_comb begin
        busy     = (sel == 0) ? b0.busy     : (sel == 1) ? b1.busy     : b2.busy;
        done     = (sel == 0) ? b0.done     : (sel == 1) ? b1.done     : b2.done;
        rdm_load = (sel == 0) ? b0.rdm_load : (sel == 1) ? b1.rdm_load : b2.rdm_load;
        rdata    = (sel == 0) ? b0.rdata    : (sel == 1) ? b1.rdata    : b2.rdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s (dut %0d): got %0h, expected %0h", tag, sel, got, exp);
        end
    endtask

    // one complete access; inputs are scrambled while the DUT is busy to prove they are ignored
    task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d, input bit poke);
        int n;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        n = 0;
        while (!done && n < lat[sel] + 4) begin
            req   = poke ? 1'b1 : 1'($urandom);
            we    = poke ? 1'b1 : 1'($urandom);
            addr  = (poke && n == 0) ? a : 8'($urandom);
            wdata = poke ? 16'h2222 : 16'($urandom);
            @(posedge clk); #1;
            n++;
            if (!done) chk("access_busy", busy, 1);
        end
        chk("latency", n, lat[sel]);
        if (w) begin
            mem_m[sel][a] = d;
            val_m[sel][a] = 1'b1;
        end else begin
            rd_m[sel] = mem_m[sel][a];
        end
        chk("resp_done", done, 1);
        chk("resp_busy", busy, 1);
        chk("resp_rdm_load", rdm_load, !w);
        chk("resp_rdata", rdata, rd_m[sel]);
        req = 1'($urandom);
        we  = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_rdm_load", rdm_load, 0);
        chk("idle_rdata", rdata, rd_m[sel]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ld, loads, last;
        logic prev;
        logic [7:0] a;
        logic w;
        sel = 0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        rd_m = '{default: 16'h0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rdm_load", rdm_load, 0);
            chk("rst_rdata", rdata, 0);
        end
        sel = 0;
        repeat (3) @(posedge clk);
        #1 chk("idle_no_req", busy, 0);

        access(1'b1, 8'h3C, 16'hBEEF, 0);
        access(1'b0, 8'h3C, 16'h0000, 0);

        access(1'b1, 8'h01, 16'h1111, 0);
        access(1'b0, 8'h01, 16'h0000, 1);
        access(1'b0, 8'h01, 16'h0000, 0);

        access(1'b1, 8'h10, 16'h5555, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 16'hAAAA;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (lat[0] - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_m = '{default: 16'h0};
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rdata", rdata, 0);
        access(1'b0, 8'h10, 16'h0000, 0);

        access(1'b1, 8'h00, 16'h000A, 0);
        access(1'b1, 8'h01, 16'h000B, 0);
        access(1'b1, 8'h02, 16'h000C, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h00;
        acc = 0; ld = 0; loads = 0; last = 0; prev = 1'b0;
        for (int c = 1; c <= 60 && ld < 3; c++) begin
            @(posedge clk); #1;
            if (busy && !prev) begin
                if (acc > 0) chk("b2b_spacing", c - last, lat[0] + 2);
                last = c;
                acc++;
                addr = 8'(acc);
            end
            if (rdm_load) loads++;
            if (done) begin
                chk("b2b_rdata", rdata, 16'h000A + 16'(ld));
                ld++;
            end
            prev = busy;
        end
        req = 1'b0;
        rd_m[0] = 16'h000C;
        chk("b2b_accepts", acc, 3);
        chk("b2b_loads", loads, 3);
        @(posedge clk); #1;
        chk("b2b_idle", busy, 0);

        for (int s = 1; s < 3; s++) begin
            sel = s;
            access(1'b1, 8'h00, 16'h1234 + 16'(s), 0);
            access(1'b1, 8'hFF, 16'hFEDC - 16'(s), 0);
            access(1'b0, 8'h00, 16'h0000, 0);
            access(1'b0, 8'hFF, 16'h0000, 0);
        end

        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 30; i++) begin
                a = 8'($urandom_range(0, 15));
                w = !val_m[s][a] || 1'($urandom);
                access(w, a, 16'($urandom), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
